signed_spm_fsm: RTL and testbench



---
 rtl/signed_spm_fsm.sv | 122 ++++++++++++
 tb/tb_signed_spm_fsm.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/signed_spm_fsm.sv
// Signed 8x8 serial-parallel multiplier: latches operands on start, produces one
// product bit per cycle for 16 cycles, then presents the 16-bit product with done.
module signed_spm_fsm (
  input  logic        clk,
  input  logic        rst,
  input  logic        startOperation,
  input  logic [7:0]  x,
  input  logic [7:0]  y,
  output logic [15:0] out,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  mcand_q, mcand_d;
  logic [7:0]  mplr_q, mplr_d;
  logic [8:0]  acc_q, acc_d;
  logic [15:0] prod_q, prod_d;
  logic [15:0] out_q, out_d;
  logic        done_q, done_d;
  logic [9:0]  sum_s;

  assign out  = out_q;
  assign done = done_q;

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      mcand_q <= 8'd0;
      mplr_q  <= 8'd0;
      acc_q   <= 9'd0;
      prod_q  <= 16'd0;
      out_q   <= 16'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      acc_q   <= acc_d;
      prod_q  <= prod_d;
      out_q   <= out_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (startOperation) state_d = RUN;
        else                state_d = IDLE;
      end
      RUN: begin
        if (cnt_q == 4'd15) state_d = DONE;
        else                state_d = RUN;
      end
      DONE: begin
        if (startOperation) state_d = RUN;
        else                state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Partial-sum adder: |acc| stays below |x|, so 10 bits never overflow
  always_comb begin
    if (mplr_q[0]) sum_s = {{2{acc_q[8]}}, acc_q} + {{2{mcand_q[7]}}, mcand_q};
    else           sum_s = {{2{acc_q[8]}}, acc_q};
  end

  // Datapath and registered-output next values
  always_comb begin
    cnt_d   = cnt_q;
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    acc_d   = acc_q;
    prod_d  = prod_q;
    out_d   = out_q;
    done_d  = done_q;
    case (state_q)
      IDLE, DONE: begin
        if (startOperation) begin
          mcand_d = x;
          mplr_d  = y;
          acc_d   = 9'd0;
          prod_d  = 16'd0;
          cnt_d   = 4'd0;
          done_d  = 1'b0;
        end else begin
          done_d  = (state_q == DONE);
        end
      end
      RUN: begin
        // Arithmetic shift of the multiplier supplies y[7] for bits 8..15
        mplr_d = {mplr_q[7], mplr_q[7:1]};
        acc_d  = sum_s[9:1];
        prod_d = {sum_s[0], prod_q[15:1]};
        cnt_d  = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          out_d  = {sum_s[0], prod_q[15:1]};
          done_d = 1'b1;
        end else begin
          done_d = 1'b0;
        end
      end
      default: begin
        done_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_signed_spm_fsm.sv
// Directed bench for signed_spm_fsm: table of hand-computed products plus
// sequences for mid-run reset, ignored starts and continuously held start.
module tb_signed_spm_fsm;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  x_s;
  logic [7:0]  y_s;
  logic [15:0] out_s;
  logic        done_s;

  int total;
  int bad;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp;
    bit          scr;
  } vec_t;

  vec_t vecs [10];

  signed_spm_fsm dut (
    .clk            (clk),
    .rst            (rst),
    .startOperation (start),
    .x              (x_s),
    .y              (y_s),
    .out            (out_s),
    .done           (done_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] exp, input bit scr, input string nm);
    int lat;
    lat = 0;
    @(negedge clk);
    x_s = a;
    y_s = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk({nm, "_done_low"}, {31'd0, done_s}, 32'd0);
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (scr && i == 3) begin
        x_s = 8'h37;
        y_s = 8'h9D;
      end
      if (scr && i == 5) start = 1'b1;
      if (scr && i == 6) start = 1'b0;
      if (done_s) begin
        lat = i;
        break;
      end
    end
    start = 1'b0;
    chk({nm, "_latency"}, lat, 32'd16);
    chk({nm, "_out"}, {16'd0, out_s}, {16'd0, exp});
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    start = 1'b0;
    x_s   = 8'd0;
    y_s   = 8'd0;

    vecs[0] = '{a: 8'd100,  b: 8'hFE, exp: 16'hFF38, scr: 1'b0};
    vecs[1] = '{a: 8'hC0,   b: 8'hFE, exp: 16'h0080, scr: 1'b0};
    vecs[2] = '{a: 8'hFF,   b: 8'd16, exp: 16'hFFF0, scr: 1'b1};
    vecs[3] = '{a: 8'h80,   b: 8'h80, exp: 16'h4000, scr: 1'b0};
    vecs[4] = '{a: 8'h80,   b: 8'd127, exp: 16'hC080, scr: 1'b0};
    vecs[5] = '{a: 8'd0,    b: 8'hB3, exp: 16'h0000, scr: 1'b0};
    vecs[6] = '{a: 8'd127,  b: 8'd127, exp: 16'h3F01, scr: 1'b0};
    vecs[7] = '{a: 8'hF9,   b: 8'd9,  exp: 16'hFFC1, scr: 1'b1};
    vecs[8] = '{a: 8'd5,    b: 8'hFF, exp: 16'hFFFB, scr: 1'b0};
    vecs[9] = '{a: 8'h7F,   b: 8'h80, exp: 16'hC080, scr: 1'b0};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_out", {16'd0, out_s}, 32'd0);
    chk("reset_done", {31'd0, done_s}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // First operation from IDLE, then stability while start stays low
    run_op(8'd25, 8'd15, 16'h0177, 1'b0, "p25x15");
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("hold_done", {31'd0, done_s}, 32'd1);
      chk("hold_out", {16'd0, out_s}, 32'h0177);
    end

    for (int k = 0; k < 10; k++) begin
      run_op(vecs[k].a, vecs[k].b, vecs[k].exp, vecs[k].scr, $sformatf("vec%0d", k));
    end

    // Asynchronous reset five edges into a run
    @(negedge clk);
    x_s = 8'd9;
    y_s = 8'd9;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_out", {16'd0, out_s}, 32'd0);
    chk("midrst_done", {31'd0, done_s}, 32'd0);
    // A start seen only while reset is high must be lost
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    x_s = 8'd3;
    y_s = 8'd4;
    repeat (20) @(posedge clk);
    #1;
    chk("idle_done", {31'd0, done_s}, 32'd0);
    chk("idle_out", {16'd0, out_s}, 32'd0);
    run_op(8'd3, 8'hFB, 16'hFFF1, 1'b0, "after_rst");

    // Start held high: done pulses one cycle every 17 edges
    repeat (2) @(posedge clk);
    @(negedge clk);
    x_s = 8'hF4;
    y_s = 8'd11;
    start = 1'b1;
    for (int e = 0; e < 60; e++) begin
      @(posedge clk);
      #1;
      if (e == 16 || e == 33 || e == 50) begin
        chk($sformatf("held_done_e%0d", e), {31'd0, done_s}, 32'd1);
        chk($sformatf("held_out_e%0d", e), {16'd0, out_s}, 32'h0000FF7C);
      end else begin
        chk($sformatf("held_done_e%0d", e), {31'd0, done_s}, 32'd0);
      end
    end
    start = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
